// File: rtl/gpio_debounce.sv
// Pad input conditioning: 2-flop synchronizer, shared sample-tick prescaler,
// per-bit consecutive-sample debouncer with registered rise/fall/change pulses.
module gpio_debounce #(
  parameter int WIDTH          = 32,
  parameter int PRESC          = 1000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] gpio_bi_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o,
  output logic             tick_o
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESC - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_SAMPLES - 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             change_q, change_d;
  logic             tick;

  always_comb begin
    s1_d     = pins_i;
    s2_d     = s1_q;
    tick     = (pcnt_q == PCNT_LAST);
    pcnt_d   = tick ? '0 : pcnt_q + PW'(1);
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    cnt_d    = cnt_q;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        // Any sample matching the accepted level restarts the run of differing samples.
        if (s2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s2_q[i];
          cnt_d[i]    = '0;
          rise_d[i]   = s2_q[i];
          fall_d[i]   = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    change_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q     <= '0;
      s2_q     <= '0;
      pcnt_q   <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      pcnt_q   <= pcnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign gpio_bi_o = stable_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign change_o  = change_q;
  assign tick_o    = tick;

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: two instances (PRESC=1/SS=4 and PRESC=4/SS=3) compared
// every cycle against a sample-history reference model, plus directed scenarios.
module tb_gpio_debounce;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] pins_i;

  logic [31:0] gpio_f, rise_f, fall_f;
  logic        change_f, tick_f;
  logic [31:0] gpio_s, rise_s, fall_s;
  logic        change_s, tick_s;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  gpio_debounce #(.WIDTH(32), .PRESC(1), .STABLE_SAMPLES(4)) u_fast (
    .clk_i(clk), .rst_i(rst_i), .pins_i(pins_i),
    .gpio_bi_o(gpio_f), .rise_o(rise_f), .fall_o(fall_f),
    .change_o(change_f), .tick_o(tick_f)
  );

  gpio_debounce #(.WIDTH(32), .PRESC(4), .STABLE_SAMPLES(3)) u_slow (
    .clk_i(clk), .rst_i(rst_i), .pins_i(pins_i),
    .gpio_bi_o(gpio_s), .rise_o(rise_s), .fall_o(fall_s),
    .change_o(change_s), .tick_o(tick_s)
  );

  // ---------------- reference model ----------------
  // Keeps the pad history, a cycle count since reset, and the last few tick samples;
  // a level is accepted once the most recent STABLE_SAMPLES tick samples taken since
  // the previous acceptance all disagree with the accepted level.
  int          m_pc    [2];
  logic [31:0] m_d1    [2];
  logic [31:0] m_d2    [2];
  logic [31:0] m_stable[2];
  logic [31:0] m_rise  [2];
  logic [31:0] m_fall  [2];
  logic        m_chg   [2];
  logic [31:0] m_hist  [2][4];
  int          m_since [2][32];

  logic [31:0] exp_q[$];

  int ev_rise_f[32], ev_fall_f[32], ev_rise_s[32], ev_fall_s[32];
  int ev_chg_f, ev_chg_s;

  function automatic int presc_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int ss_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic model_clear(input int k);
    m_pc[k] = 0; m_d1[k] = '0; m_d2[k] = '0; m_stable[k] = '0;
    m_rise[k] = '0; m_fall[k] = '0; m_chg[k] = 1'b0;
    for (int j = 0; j < 4; j++) m_hist[k][j] = '0;
    for (int i = 0; i < 32; i++) m_since[k][i] = 0;
  endtask

  task automatic model_edge(input int k, input logic r, input logic [31:0] p);
    int          pr, ss;
    logic [31:0] samp;
    bit          all_diff;
    pr = presc_of(k);
    ss = ss_of(k);
    if (r) begin
      model_clear(k);
    end else begin
      m_rise[k] = '0;
      m_fall[k] = '0;
      if (m_pc[k] == pr - 1) begin
        samp = m_d2[k];
        for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = samp;
        for (int i = 0; i < 32; i++) begin
          m_since[k][i]++;
          if (m_since[k][i] >= ss) begin
            all_diff = 1'b1;
            for (int j = 0; j < ss; j++)
              if (m_hist[k][j][i] == m_stable[k][i]) all_diff = 1'b0;
            if (all_diff) begin
              m_stable[k][i] = samp[i];
              if (samp[i]) m_rise[k][i] = 1'b1;
              else         m_fall[k][i] = 1'b1;
              m_since[k][i] = 0;
            end
          end
        end
      end
      m_pc[k] = (m_pc[k] + 1) % pr;
      m_d2[k] = m_d1[k];
      m_d1[k] = p;
      m_chg[k] = |(m_rise[k] | m_fall[k]);
    end
    exp_q.push_back(m_stable[k]);
    exp_q.push_back(m_rise[k]);
    exp_q.push_back(m_fall[k]);
    exp_q.push_back(32'(m_chg[k]));
    exp_q.push_back(32'(m_pc[k] == pr - 1));
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("f_gpio",  gpio_f,          exp_q.pop_front());
    check("f_rise",  rise_f,          exp_q.pop_front());
    check("f_fall",  fall_f,          exp_q.pop_front());
    check("f_chg",   32'(change_f),   exp_q.pop_front());
    check("f_tick",  32'(tick_f),     exp_q.pop_front());
    check("s_gpio",  gpio_s,          exp_q.pop_front());
    check("s_rise",  rise_s,          exp_q.pop_front());
    check("s_fall",  fall_s,          exp_q.pop_front());
    check("s_chg",   32'(change_s),   exp_q.pop_front());
    check("s_tick",  32'(tick_s),     exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge(0, rst_i, pins_i);
    model_edge(1, rst_i, pins_i);
    #1;
    compare_all();
    for (int i = 0; i < 32; i++) begin
      ev_rise_f[i] += int'(rise_f[i]);
      ev_fall_f[i] += int'(fall_f[i]);
      ev_rise_s[i] += int'(rise_s[i]);
      ev_fall_s[i] += int'(fall_s[i]);
    end
    ev_chg_f += int'(change_f);
    ev_chg_s += int'(change_s);
  endtask

  task automatic clear_events();
    for (int i = 0; i < 32; i++) begin
      ev_rise_f[i] = 0; ev_fall_f[i] = 0; ev_rise_s[i] = 0; ev_fall_s[i] = 0;
    end
    ev_chg_f = 0;
    ev_chg_s = 0;
  endtask

  task automatic settle(input logic [31:0] v);
    pins_i = v;
    repeat (40) step();
    clear_events();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, lat2;
    model_clear(0);
    model_clear(1);
    clear_events();
    rst_i  = 1'b1;
    pins_i = 32'hFFFF_FFFF;

    // Reset values with all pins held high, then re-acceptance as a normal rise.
    repeat (3) begin
      step();
      check("rst_gpio", gpio_f | gpio_s, 32'h0);
      check("rst_pulse", rise_f | fall_f | rise_s | fall_s, 32'h0);
      check("rst_chg", 32'({change_f, change_s}), 32'h0);
    end
    rst_i = 1'b0;
    repeat (5) step();
    check("rel_gpio_early", gpio_f, 32'h0);
    step();
    check("rel_gpio", gpio_f, 32'hFFFF_FFFF);
    check("rel_rise", rise_f, 32'hFFFF_FFFF);
    check("rel_chg", 32'(change_f), 32'h1);
    step();
    check("rel_rise_once", rise_f, 32'h0);

    // Glitch of 3 cycles on bit 5 is rejected.
    settle(32'h0);
    pins_i[5] = 1'b1;
    repeat (3) step();
    pins_i[5] = 1'b0;
    repeat (20) step();
    check("gl3_gpio", 32'(gpio_f[5]), 32'h0);
    check("gl3_rise", 32'(ev_rise_f[5]), 32'h0);
    check("gl3_fall", 32'(ev_fall_f[5]), 32'h0);

    // 4-cycle pulse is accepted; fall follows 6 cycles after the input falls.
    clear_events();
    pins_i[5] = 1'b1;
    repeat (4) step();
    pins_i[5] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (fall_f[5] && lat < 0) lat = k;
    end
    check("gl4_rise", 32'(ev_rise_f[5]), 32'h1);
    check("gl4_fall", 32'(ev_fall_f[5]), 32'h1);
    check("gl4_fall_lat", 32'(lat), 32'd6);

    // Opposite-direction changes on bits 0 and 31 in the same cycle.
    settle(32'h8000_0000);
    pins_i = 32'h0000_0001;
    lat = -1; lat2 = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (rise_f[0] && lat < 0)   lat = k;
      if (fall_f[31] && lat2 < 0) lat2 = k;
    end
    check("sim_rise_lat", 32'(lat), 32'd6);
    check("sim_fall_lat", 32'(lat2), 32'd6);
    check("sim_chg_f", 32'(ev_chg_f), 32'h1);
    check("sim_chg_s", 32'(ev_chg_s), 32'h1);

    // Prescaled latency on the PRESC=4 / SS=3 instance.
    settle(32'h0);
    pins_i[0] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (gpio_s[0] && lat < 0) lat = k;
    end
    check("ps_lat_range", 32'(lat >= 11 && lat <= 14), 32'h1);
    check("ps_rise", 32'(ev_rise_s[0]), 32'h1);

    // Bouncing bit 3: each level lasts exactly 2 ticks of the slow instance.
    settle(32'h0);
    for (int seg = 0; seg < 10; seg++) begin
      pins_i[3] = (seg % 2 == 0);
      repeat (8) step();
    end
    check("bnc_rise", 32'(ev_rise_s[3]), 32'h0);
    check("bnc_fall", 32'(ev_fall_s[3]), 32'h0);
    pins_i[3] = 1'b1;
    clear_events();
    repeat (20) step();
    check("bnc_settle_rise", 32'(ev_rise_s[3]), 32'h1);
    check("bnc_settle_gpio", 32'(gpio_s[3]), 32'h1);

    // Reset when the fast counter has reached 3 of 4.
    settle(32'h0);
    pins_i[7] = 1'b1;
    repeat (5) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (rise_f[7] && lat < 0) lat = k;
    end
    check("rmc_lat", 32'(lat), 32'd6);
    check("rmc_rise_cnt", 32'(ev_rise_f[7]), 32'h1);

    // Randomized sparse toggling with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0)
        pins_i = pins_i ^ ($urandom() & $urandom() & $urandom());
      rst_i = ($urandom_range(0, 499) == 0);
      step();
    end
    rst_i = 1'b0;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
